// File: rtl/axil_adapter_rd.sv
// -----------------------------------------------------------------------------
// axil_adapter_rd
// AXI4-Lite read-channel data-width adapter. Connects an upstream master
// (s_axil_* slave port) to a downstream slave of a different data width
// (m_axil_* master port).
//   - Same width: each read is forwarded once and the data passed through.
//   - Wider downstream (EXPAND): one downstream read, the upstream-sized lane
//     selected by the address is extracted.
//   - Narrower downstream: one upstream read becomes several sequential
//     downstream reads, assembled into a single upstream response. The
//     response code is the last non-OKAY seen, otherwise OKAY.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axil_ar*          upstream read address channel
//   s_axil_r*           upstream read data channel (registered outputs)
//   m_axil_ar*          downstream read address channel (registered outputs)
//   m_axil_r*           downstream read data channel
// All outputs are registered; there is no combinational path between ports.
// -----------------------------------------------------------------------------
module axil_adapter_rd #(
  parameter int ADDR_WIDTH   = 32,
  parameter int S_DATA_WIDTH = 32,
  parameter int S_STRB_WIDTH = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH = 32,
  parameter int M_STRB_WIDTH = M_DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [S_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,

  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [M_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  localparam int  S_OFF     = $clog2(S_STRB_WIDTH);
  localparam int  M_OFF     = $clog2(M_STRB_WIDTH);
  localparam bit  EXPAND    = (M_STRB_WIDTH > S_STRB_WIDTH);
  localparam bit  NARROW    = (S_STRB_WIDTH > M_STRB_WIDTH);
  localparam int  SEG_COUNT = EXPAND ? (M_STRB_WIDTH / S_STRB_WIDTH) : (S_STRB_WIDTH / M_STRB_WIDTH);
  localparam int  SEG_DW    = EXPAND ? S_DATA_WIDTH : M_DATA_WIDTH;
  localparam int  SEG_W     = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
  // Segments in the upstream word (assembly) and in the downstream word (lane pick)
  localparam int  ASM_SEGS  = S_DATA_WIDTH / SEG_DW;
  localparam int  EXT_SEGS  = M_DATA_WIDTH / SEG_DW;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  if ((S_STRB_WIDTH & (S_STRB_WIDTH - 1)) != 0) begin : g_bad_s_strb
    $error("axil_adapter_rd: S_STRB_WIDTH must be a power of two");
  end
  if ((M_STRB_WIDTH & (M_STRB_WIDTH - 1)) != 0) begin : g_bad_m_strb
    $error("axil_adapter_rd: M_STRB_WIDTH must be a power of two");
  end
  if ((S_DATA_WIDTH / S_STRB_WIDTH) != (M_DATA_WIDTH / M_STRB_WIDTH)) begin : g_bad_word
    $error("axil_adapter_rd: byte-lane size must match on both ports");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t                  state_r;
  logic                    s_arready_r;
  logic [S_DATA_WIDTH-1:0] s_rdata_r;
  logic [1:0]              s_rresp_r;
  logic                    s_rvalid_r;
  logic [ADDR_WIDTH-1:0]   m_araddr_r;
  logic [2:0]              m_arprot_r;
  logic                    m_arvalid_r;
  logic                    m_rready_r;
  logic [SEG_W-1:0]        seg_r;
  logic [S_DATA_WIDTH-1:0] asm_r;
  logic [1:0]              resp_r;

  logic [SEG_W-1:0]        lane_s;
  logic [SEG_DW-1:0]       lane_data_s;
  logic [S_DATA_WIDTH-1:0] ext_rdata_s;
  logic [SEG_W-1:0]        start_seg_s;
  logic [S_DATA_WIDTH-1:0] asm_next_s;
  logic [1:0]              resp_next_s;
  logic                    seg_last_s;
  logic [ADDR_WIDTH-1:0]   next_addr_s;

  assign s_axil_arready = s_arready_r;
  assign s_axil_rdata   = s_rdata_r;
  assign s_axil_rresp   = s_rresp_r;
  assign s_axil_rvalid  = s_rvalid_r;
  assign m_axil_araddr  = m_araddr_r;
  assign m_axil_arprot  = m_arprot_r;
  assign m_axil_arvalid = m_arvalid_r;
  assign m_axil_rready  = m_rready_r;

  // Datapath helpers: lane extraction, segment assembly, response merge, next address
  always_comb begin
    // Lane of the wide downstream word holding the requested upstream word
    if (EXPAND) begin
      lane_s = SEG_W'(m_araddr_r >> S_OFF);
    end else begin
      lane_s = {SEG_W{1'b0}};
    end

    lane_data_s = {SEG_DW{1'b0}};
    for (int i = 0; i < EXT_SEGS; i++) begin
      lane_data_s = lane_data_s |
                    ((lane_s == SEG_W'(i)) ? m_axil_rdata[i*SEG_DW +: SEG_DW] : {SEG_DW{1'b0}});
    end
    ext_rdata_s = S_DATA_WIDTH'(lane_data_s);

    // First segment an unaligned narrow read starts at; lower segments stay zero
    if (NARROW) begin
      start_seg_s = SEG_W'(s_axil_araddr >> M_OFF);
    end else begin
      start_seg_s = {SEG_W{1'b0}};
    end

    for (int i = 0; i < ASM_SEGS; i++) begin
      asm_next_s[i*SEG_DW +: SEG_DW] = (seg_r == SEG_W'(i)) ? m_axil_rdata[SEG_DW-1:0]
                                                            : asm_r[i*SEG_DW +: SEG_DW];
    end

    // Last non-OKAY response wins
    resp_next_s = (m_axil_rresp != RESP_OKAY) ? m_axil_rresp : resp_r;
    seg_last_s  = (seg_r == SEG_W'(SEG_COUNT - 1));
    next_addr_s = (m_araddr_r & ~ADDR_WIDTH'(M_STRB_WIDTH - 1)) + ADDR_WIDTH'(M_STRB_WIDTH);
  end

  // Control FSM with all port outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      s_arready_r <= 1'b0;
      s_rdata_r   <= {S_DATA_WIDTH{1'b0}};
      s_rresp_r   <= 2'b00;
      s_rvalid_r  <= 1'b0;
      m_araddr_r  <= {ADDR_WIDTH{1'b0}};
      m_arprot_r  <= 3'b000;
      m_arvalid_r <= 1'b0;
      m_rready_r  <= 1'b0;
      seg_r       <= {SEG_W{1'b0}};
      asm_r       <= {S_DATA_WIDTH{1'b0}};
      resp_r      <= 2'b00;
    end else begin
      m_arvalid_r <= m_arvalid_r && !m_axil_arready;
      s_rvalid_r  <= s_rvalid_r && !s_axil_rready;
      s_arready_r <= 1'b0;
      m_rready_r  <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          s_arready_r <= !m_arvalid_r;
          if (s_axil_arready && s_axil_arvalid) begin
            s_arready_r <= 1'b0;
            m_araddr_r  <= s_axil_araddr;
            m_arprot_r  <= s_axil_arprot;
            m_arvalid_r <= 1'b1;
            // A still-pending upstream response blocks the downstream R channel
            m_rready_r  <= !s_rvalid_r;
            seg_r       <= start_seg_s;
            asm_r       <= {S_DATA_WIDTH{1'b0}};
            resp_r      <= RESP_OKAY;
            state_r     <= ST_DATA;
          end
        end

        ST_DATA: begin
          m_rready_r <= !s_rvalid_r;
          if (m_rready_r && m_axil_rvalid) begin
            if (NARROW) begin
              asm_r  <= asm_next_s;
              resp_r <= resp_next_s;
              if (seg_last_s) begin
                s_rdata_r   <= asm_next_s;
                s_rresp_r   <= resp_next_s;
                s_rvalid_r  <= 1'b1;
                m_rready_r  <= 1'b0;
                s_arready_r <= !m_arvalid_r;
                state_r     <= ST_IDLE;
              end else begin
                seg_r       <= seg_r + SEG_W'(1);
                m_araddr_r  <= next_addr_s;
                m_arvalid_r <= 1'b1;
              end
            end else begin
              s_rdata_r   <= ext_rdata_s;
              s_rresp_r   <= m_axil_rresp;
              s_rvalid_r  <= 1'b1;
              m_rready_r  <= 1'b0;
              s_arready_r <= !m_arvalid_r;
              state_r     <= ST_IDLE;
            end
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_adapter_rd.sv
// -----------------------------------------------------------------------------
// tb_axil_adapter_rd
// Self-checking bench for axil_adapter_rd. Three instances cover the width
// modes: index 0 = 32/32, index 1 = S32/M64 (expand), index 2 = S64/M32
// (narrow). A table of directed read vectors with hand-computed results is
// applied in a loop; backpressure and mid-transaction reset are hand-written
// sequences. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axil_adapter_rd;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Inputs, one element per instance
  logic [31:0] s_araddr  [3];
  logic [2:0]  s_arprot  [3];
  logic        s_arvalid [3];
  logic        s_rready  [3];
  logic        m_arready [3];
  logic [63:0] m_rdata   [3];
  logic [1:0]  m_rresp   [3];
  logic        m_rvalid  [3];

  // Outputs
  logic        s_arready_o [3];
  logic [1:0]  s_rresp_o   [3];
  logic        s_rvalid_o  [3];
  logic [31:0] m_araddr_o  [3];
  logic [2:0]  m_arprot_o  [3];
  logic        m_arvalid_o [3];
  logic        m_rready_o  [3];
  logic [31:0] s_rdata0;
  logic [31:0] s_rdata1;
  logic [63:0] s_rdata2;

  axil_adapter_rd #(.ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(32)) u_same (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_araddr[0]), .s_axil_arprot(s_arprot[0]), .s_axil_arvalid(s_arvalid[0]),
    .s_axil_arready(s_arready_o[0]), .s_axil_rdata(s_rdata0), .s_axil_rresp(s_rresp_o[0]),
    .s_axil_rvalid(s_rvalid_o[0]), .s_axil_rready(s_rready[0]),
    .m_axil_araddr(m_araddr_o[0]), .m_axil_arprot(m_arprot_o[0]), .m_axil_arvalid(m_arvalid_o[0]),
    .m_axil_arready(m_arready[0]), .m_axil_rdata(m_rdata[0][31:0]), .m_axil_rresp(m_rresp[0]),
    .m_axil_rvalid(m_rvalid[0]), .m_axil_rready(m_rready_o[0])
  );

  axil_adapter_rd #(.ADDR_WIDTH(32), .S_DATA_WIDTH(32), .M_DATA_WIDTH(64)) u_exp (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_araddr[1]), .s_axil_arprot(s_arprot[1]), .s_axil_arvalid(s_arvalid[1]),
    .s_axil_arready(s_arready_o[1]), .s_axil_rdata(s_rdata1), .s_axil_rresp(s_rresp_o[1]),
    .s_axil_rvalid(s_rvalid_o[1]), .s_axil_rready(s_rready[1]),
    .m_axil_araddr(m_araddr_o[1]), .m_axil_arprot(m_arprot_o[1]), .m_axil_arvalid(m_arvalid_o[1]),
    .m_axil_arready(m_arready[1]), .m_axil_rdata(m_rdata[1]), .m_axil_rresp(m_rresp[1]),
    .m_axil_rvalid(m_rvalid[1]), .m_axil_rready(m_rready_o[1])
  );

  axil_adapter_rd #(.ADDR_WIDTH(32), .S_DATA_WIDTH(64), .M_DATA_WIDTH(32)) u_nar (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_araddr[2]), .s_axil_arprot(s_arprot[2]), .s_axil_arvalid(s_arvalid[2]),
    .s_axil_arready(s_arready_o[2]), .s_axil_rdata(s_rdata2), .s_axil_rresp(s_rresp_o[2]),
    .s_axil_rvalid(s_rvalid_o[2]), .s_axil_rready(s_rready[2]),
    .m_axil_araddr(m_araddr_o[2]), .m_axil_arprot(m_arprot_o[2]), .m_axil_arvalid(m_arvalid_o[2]),
    .m_axil_arready(m_arready[2]), .m_axil_rdata(m_rdata[2][31:0]), .m_axil_rresp(m_rresp[2]),
    .m_axil_rvalid(m_rvalid[2]), .m_axil_rready(m_rready_o[2])
  );

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] addr;
    logic [1:0]  nbeats;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  r0;
    logic [1:0]  r1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [1:0] dut, input logic [31:0] addr, input logic [1:0] nb,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [1:0] r0, input logic [1:0] r1,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [63:0] er, input logic [1:0] ep);
    vec_t v;
    v.dut = dut; v.addr = addr; v.nbeats = nb; v.d0 = d0; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.exp_rdata = er; v.exp_rresp = ep;
    return v;
  endfunction

  function automatic logic [63:0] srdata(input int d);
    case (d)
      0:       return {32'd0, s_rdata0};
      1:       return {32'd0, s_rdata1};
      default: return s_rdata2;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_s_arready", 64'(s_arready_o[d]), 64'd0);
    check("rst_s_rvalid",  64'(s_rvalid_o[d]),  64'd0);
    check("rst_m_arvalid", 64'(m_arvalid_o[d]), 64'd0);
    check("rst_m_rready",  64'(m_rready_o[d]),  64'd0);
    check("rst_m_araddr",  64'(m_araddr_o[d]),  64'd0);
    check("rst_m_arprot",  64'(m_arprot_o[d]),  64'd0);
    check("rst_s_rdata",   srdata(d),           64'd0);
    check("rst_s_rresp",   64'(s_rresp_o[d]),   64'd0);
  endtask

  // Present an upstream AR and hold it until accepted; returns on the
  // falling edge after the accepting rising edge.
  task automatic do_ar(input int d, input logic [31:0] addr, input logic [2:0] prot);
    int n;
    s_araddr[d] = addr; s_arprot[d] = prot; s_arvalid[d] = 1'b1;
    n = 0;
    while (!s_arready_o[d] && n < 20) begin @(negedge clk); n++; end
    check("ar_accept_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    s_arvalid[d] = 1'b0;
  endtask

  // One downstream round trip: expect an AR immediately, then return one R beat.
  task automatic do_beat(input int d, input logic [31:0] exp_ar, input logic [2:0] exp_prot,
                         input logic [63:0] data, input logic [1:0] resp);
    int n;
    n = 0;
    while (!m_arvalid_o[d] && n < 20) begin @(negedge clk); n++; end
    check("ar_latency", 64'(n), 64'd0);
    check("ar_addr", 64'(m_araddr_o[d]), 64'(exp_ar));
    check("ar_prot", 64'(m_arprot_o[d]), 64'(exp_prot));
    @(negedge clk);
    m_rvalid[d] = 1'b1; m_rdata[d] = data; m_rresp[d] = resp;
    n = 0;
    while (!m_rready_o[d] && n < 20) begin @(negedge clk); n++; end
    check("r_accept_timeout", 64'(n < 20), 64'd1);
    @(negedge clk);
    m_rvalid[d] = 1'b0;
  endtask

  // Upstream response must already be valid; optionally accept it.
  task automatic finish(input int d, input logic [63:0] exp_rdata, input logic [1:0] exp_rresp,
                        input bit hold);
    check("s_rvalid", 64'(s_rvalid_o[d]), 64'd1);
    check("s_rdata", srdata(d), exp_rdata);
    check("s_rresp", 64'(s_rresp_o[d]), 64'(exp_rresp));
    check("no_extra_ar", 64'(m_arvalid_o[d]), 64'd0);
    if (!hold) begin
      s_rready[d] = 1'b1;
      @(negedge clk);
      s_rready[d] = 1'b0;
      check("s_rvalid_clear", 64'(s_rvalid_o[d]), 64'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [2:0] prot, input bit hold);
    int d;
    d = int'(v.dut);
    do_ar(d, v.addr, prot);
    do_beat(d, v.a0, prot, v.d0, v.r0);
    if (v.nbeats == 2'd2) begin
      do_beat(d, v.a1, prot, v.d1, v.r1);
    end
    finish(d, v.exp_rdata, v.exp_rresp, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //         dut   addr          nb    d0                     d1             r0     r1     a0            a1            exp_rdata              exp_rresp
    vecs[0] = mk(2'd0, 32'h0000_1000, 2'd1, 64'hDEADBEEF,          64'h0,         2'd0, 2'd0, 32'h0000_1000, 32'h0,        64'hDEADBEEF,          2'd0);
    vecs[1] = mk(2'd0, 32'h0000_0010, 2'd1, 64'h12345678,          64'h0,         2'd2, 2'd0, 32'h0000_0010, 32'h0,        64'h12345678,          2'd2);
    vecs[2] = mk(2'd1, 32'h0000_1004, 2'd1, 64'h11223344_55667788, 64'h0,         2'd0, 2'd0, 32'h0000_1004, 32'h0,        64'h11223344,          2'd0);
    vecs[3] = mk(2'd1, 32'h0000_1000, 2'd1, 64'h11223344_55667788, 64'h0,         2'd0, 2'd0, 32'h0000_1000, 32'h0,        64'h55667788,          2'd0);
    vecs[4] = mk(2'd1, 32'h0000_0008, 2'd1, 64'hAAAABBBB_CCCCDDDD, 64'h0,         2'd3, 2'd0, 32'h0000_0008, 32'h0,        64'hCCCCDDDD,          2'd3);
    vecs[5] = mk(2'd2, 32'h0000_2000, 2'd2, 64'hAAAAAAAA,          64'hBBBBBBBB,  2'd0, 2'd0, 32'h0000_2000, 32'h0000_2004, 64'hBBBBBBBB_AAAAAAAA, 2'd0);
    vecs[6] = mk(2'd2, 32'h0000_2004, 2'd1, 64'hCCCCCCCC,          64'h0,         2'd0, 2'd0, 32'h0000_2004, 32'h0,        64'hCCCCCCCC_00000000, 2'd0);
    vecs[7] = mk(2'd2, 32'h0000_2000, 2'd2, 64'h01010101,          64'h02020202,  2'd0, 2'd2, 32'h0000_2000, 32'h0000_2004, 64'h02020202_01010101, 2'd2);
    vecs[8] = mk(2'd2, 32'h0000_2010, 2'd2, 64'h03030303,          64'h04040404,  2'd3, 2'd0, 32'h0000_2010, 32'h0000_2014, 64'h04040404_03030303, 2'd3);
    vecs[9] = mk(2'd2, 32'h0000_200C, 2'd1, 64'h77777777,          64'h0,         2'd2, 2'd0, 32'h0000_200C, 32'h0,        64'h77777777_00000000, 2'd2);

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      s_araddr[d] = 32'h0; s_arprot[d] = 3'd0; s_arvalid[d] = 1'b0; s_rready[d] = 1'b0;
      m_arready[d] = 1'b1; m_rdata[d] = 64'h0; m_rresp[d] = 2'd0; m_rvalid[d] = 1'b0;
    end

    // Reset state, then s_axil_arready one edge after release
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("arready_after_reset", 64'(s_arready_o[d]), 64'd1);

    // Table-driven directed reads
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], 3'(i), 1'b0);
    end

    // Backpressure: first response held while a second read is issued
    run_vec(mk(2'd2, 32'h0000_2000, 2'd2, 64'h11111111, 64'h22222222, 2'd0, 2'd0,
               32'h0000_2000, 32'h0000_2004, 64'h22222222_11111111, 2'd0), 3'd6, 1'b1);
    do_ar(2, 32'h0000_2008, 3'd5);
    n = 0;
    while (!m_arvalid_o[2] && n < 20) begin @(negedge clk); n++; end
    check("bp_ar_addr", 64'(m_araddr_o[2]), 64'h2008);
    @(negedge clk);
    m_rvalid[2] = 1'b1; m_rdata[2] = 64'h33333333; m_rresp[2] = 2'd0;
    for (int i = 0; i < 10; i++) begin
      check("bp_m_rready_low", 64'(m_rready_o[2]), 64'd0);
      check("bp_s_rvalid_held", 64'(s_rvalid_o[2]), 64'd1);
      check("bp_s_rdata_stable", srdata(2), 64'h22222222_11111111);
      @(negedge clk);
    end
    s_rready[2] = 1'b1;
    @(negedge clk);
    s_rready[2] = 1'b0;
    check("bp_s_rvalid_clear", 64'(s_rvalid_o[2]), 64'd0);
    check("bp_m_rready_lag", 64'(m_rready_o[2]), 64'd0);
    n = 0;
    while (!m_rready_o[2] && n < 20) begin @(negedge clk); n++; end
    check("bp_m_rready_rise", 64'(n), 64'd1);
    @(negedge clk);
    m_rvalid[2] = 1'b0;
    do_beat(2, 32'h0000_200C, 3'd5, 64'h44444444, 2'd0);
    finish(2, 64'h44444444_33333333, 2'd0, 1'b0);

    // Reset in DATA after the first narrow beat aborts the read
    do_ar(2, 32'h0000_3000, 3'd1);
    do_beat(2, 32'h0000_3000, 3'd1, 64'h12121212, 2'd0);
    check("mid_second_ar_pending", 64'(m_arvalid_o[2]), 64'd1);
    rst = 1'b1;
    #1;
    check_reset(2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arready_after_midreset", 64'(s_arready_o[2]), 64'd1);
    check("no_resp_after_midreset", 64'(s_rvalid_o[2]), 64'd0);
    run_vec(mk(2'd2, 32'h0000_3000, 2'd2, 64'h55555555, 64'h66666666, 2'd0, 2'd0,
               32'h0000_3000, 32'h0000_3004, 64'h66666666_55555555, 2'd0), 3'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
